// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write path: bus widths, the default
// acceptance timeout and the issue sequencer state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W      = 7;
    localparam int I2C_DATA_W      = 8;
    localparam int I2C_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO holding {addr, data} words. The head word is
// read combinationally from storage (no prefetch register). Pushes into a
// full FIFO and pops from an empty FIFO are ignored here; the caller flags
// overflow. Occupancy is the single source of truth for full/empty.
module i2c_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/i2c_tx_sequencer.sv
// Write-command queue and issue sequencer in front of the I2C master.
// Requests are buffered in i2c_cmd_fifo and handed to the master one at a
// time over its START/READY handshake. Address/data are registered when an
// entry is popped and held until the next pop, so they stay stable through
// the whole transaction. START is a register, so READY never reaches it
// combinationally.
module i2c_tx_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = I2C_ADDR_W,
    parameter int DATA_W  = I2C_DATA_W,
    parameter int TIMEOUT = I2C_TIMEOUT_DEF
) (
    input  logic                   CLK_IW,
    input  logic                   RST_IW,
    input  logic                   WR_EN_IW,
    input  logic [ADDR_W-1:0]      WR_ADDR_IW,
    input  logic [DATA_W-1:0]      WR_DATA_IW,
    output logic                   FULL_OW,
    output logic                   EMPTY_OW,
    output logic [$clog2(DEPTH):0] COUNT_OW,
    input  logic                   M_READY_IW,
    output logic                   M_START_OR,
    output logic [ADDR_W-1:0]      M_ADDR_OR,
    output logic [DATA_W-1:0]      M_DATA_OR,
    output logic                   BUSY_OW,
    output logic                   OVF_OR,
    output logic                   TMO_OR,
    input  logic                   ERR_CLR_IW
);

    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int TMO_W  = $clog2(TIMEOUT) + 1;

    seq_state_e         state_r;
    seq_state_e         state_nxt_s;
    logic               m_start_r;
    logic               m_start_nxt_s;
    logic [ADDR_W-1:0]  m_addr_r;
    logic [ADDR_W-1:0]  m_addr_nxt_s;
    logic [DATA_W-1:0]  m_data_r;
    logic [DATA_W-1:0]  m_data_nxt_s;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic               tmo_r;
    logic               tmo_nxt_s;
    logic               tmo_evt_s;
    logic               ovf_evt_s;

    logic               fifo_pop_s;
    logic [WORD_W-1:0]  fifo_head_s;
    logic [WORD_W-1:0]  fifo_wr_word_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    assign fifo_wr_word_s = {WR_ADDR_IW, WR_DATA_IW};

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_cmd_fifo (
        .clk     (CLK_IW),
        .rst     (RST_IW),
        .push    (WR_EN_IW),
        .wr_data (fifo_wr_word_s),
        .pop     (fifo_pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Next-state, pop strobe, timeout counter and registered-output next values.
    always_comb begin
        state_nxt_s   = state_r;
        m_start_nxt_s = m_start_r;
        m_addr_nxt_s  = m_addr_r;
        m_data_nxt_s  = m_data_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        fifo_pop_s    = 1'b0;
        tmo_evt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && M_READY_IW) begin
                    fifo_pop_s    = 1'b1;
                    m_addr_nxt_s  = fifo_head_s[WORD_W-1:DATA_W];
                    m_data_nxt_s  = fifo_head_s[DATA_W-1:0];
                    m_start_nxt_s = 1'b1;
                    tmo_cnt_nxt_s = {TMO_W{1'b0}};
                    state_nxt_s   = ISSUE;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            ISSUE: begin
                if (!M_READY_IW) begin
                    m_start_nxt_s = 1'b0;
                    state_nxt_s   = WAIT_DONE;
                end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
                    // Master never took the request: drop it (already popped).
                    m_start_nxt_s = 1'b0;
                    tmo_evt_s     = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (M_READY_IW) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                m_start_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // Sticky error flags; a new error event outranks a same-cycle clear.
    always_comb begin
        ovf_evt_s = WR_EN_IW & fifo_full_s;
        ovf_nxt_s = ovf_evt_s | (ovf_r & ~ERR_CLR_IW);
        tmo_nxt_s = tmo_evt_s | (tmo_r & ~ERR_CLR_IW);
    end

    // State and registered outputs.
    always_ff @(posedge CLK_IW or posedge RST_IW) begin
        if (RST_IW) begin
            state_r   <= IDLE;
            m_start_r <= 1'b0;
            m_addr_r  <= {ADDR_W{1'b0}};
            m_data_r  <= {DATA_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
            ovf_r     <= 1'b0;
            tmo_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            m_start_r <= m_start_nxt_s;
            m_addr_r  <= m_addr_nxt_s;
            m_data_r  <= m_data_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            ovf_r     <= ovf_nxt_s;
            tmo_r     <= tmo_nxt_s;
        end
    end

    assign M_START_OR = m_start_r;
    assign M_ADDR_OR  = m_addr_r;
    assign M_DATA_OR  = m_data_r;
    assign OVF_OR     = ovf_r;
    assign TMO_OR     = tmo_r;
    assign BUSY_OW    = (state_r != IDLE);
    assign FULL_OW    = fifo_full_s;
    assign EMPTY_OW   = fifo_empty_s;
    assign COUNT_OW   = fifo_count_s;

endmodule
